// File: rtl/rr_arbiter.sv
// N-way round-robin arbiter with registered one-hot grant, grant hold while the
// owner keeps requesting, and an optional tenure bound (MAX_HOLD) that forces a
// handover when other requesters are waiting.
module rr_arbiter #(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned MAX_HOLD = 8,
  parameter int unsigned IDX_W    = $clog2(NUM_REQ)
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic [NUM_REQ-1:0] i_req,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic               o_gnt_valid,
  output logic [IDX_W-1:0]   o_gnt_idx,
  output logic               o_preempt
);

  localparam int unsigned     HOLD_W   = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);
  localparam logic [IDX_W-1:0]  LAST_RST = IDX_W'(NUM_REQ - 1);
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

  typedef enum logic {StIdle, StGrant} state_e;

  state_e              r_state, w_state_d;
  logic [NUM_REQ-1:0]  r_gnt, w_gnt_d;
  logic                r_valid, w_valid_d;
  logic [IDX_W-1:0]    r_idx, w_idx_d;
  logic [IDX_W-1:0]    r_last, w_last_d;
  logic [HOLD_W-1:0]   r_hold, w_hold_d;
  logic                r_preempt, w_preempt_d;

  logic                w_owner_req;
  logic [NUM_REQ-1:0]  w_others;
  logic                w_any_req;
  logic                w_any_other;
  logic [IDX_W-1:0]    w_pick_idle;
  logic [IDX_W-1:0]    w_pick_next;
  logic                w_grant_new;
  logic                w_drop;
  logic [IDX_W-1:0]    w_new_idx;

  // Rotating priority search: first set bit of vec starting just after base,
  // wrapping. Callers only use the result when vec is non-zero.
  function automatic logic [IDX_W-1:0] f_pick(input logic [NUM_REQ-1:0] vec,
                                              input logic [IDX_W-1:0]   base);
    logic [IDX_W-1:0] res;
    logic             found;
    int unsigned      k;
    logic [IDX_W-1:0] kk;
    res   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      k  = (32'(base) + i + 32'd1) % NUM_REQ;
      kk = k[IDX_W-1:0];
      if (!found && vec[kk]) begin
        res   = kk;
        found = 1'b1;
      end
    end
    return res;
  endfunction

  // Request decode shared by both states.
  always_comb begin
    w_owner_req = i_req[r_idx];
    w_others    = i_req & ~r_gnt;
    w_any_req   = |i_req;
    w_any_other = |w_others;
    w_pick_idle = f_pick(i_req, r_last);
    w_pick_next = f_pick(w_others, r_idx);
  end

  // Next-state decision: new grant, drop to idle, or keep the current owner.
  always_comb begin
    w_state_d   = r_state;
    w_grant_new = 1'b0;
    w_drop      = 1'b0;
    w_new_idx   = r_idx;
    w_hold_d    = r_hold;
    w_preempt_d = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_any_req) begin
          w_state_d   = StGrant;
          w_grant_new = 1'b1;
          w_new_idx   = w_pick_idle;
          w_hold_d    = HOLD_W'(1);
        end
      end
      StGrant: begin
        if (!w_owner_req) begin
          // Release wins over expiry, so preempt stays low here.
          if (w_any_other) begin
            w_grant_new = 1'b1;
            w_new_idx   = w_pick_next;
            w_hold_d    = HOLD_W'(1);
          end else begin
            w_state_d = StIdle;
            w_drop    = 1'b1;
            w_hold_d  = '0;
          end
        end else if (!w_any_other) begin
          if ((MAX_HOLD != 0) && (r_hold < HOLD_MAX)) begin
            w_hold_d = r_hold + HOLD_W'(1);
          end
        end else if ((MAX_HOLD != 0) && (r_hold >= HOLD_MAX)) begin
          w_grant_new = 1'b1;
          w_new_idx   = w_pick_next;
          w_hold_d    = HOLD_W'(1);
          w_preempt_d = 1'b1;
        end else if (MAX_HOLD != 0) begin
          w_hold_d = r_hold + HOLD_W'(1);
        end
      end
      default: begin
        w_state_d = StIdle;
        w_drop    = 1'b1;
        w_hold_d  = '0;
      end
    endcase
  end

  // Grant register contents derived from the decision above.
  always_comb begin
    w_gnt_d   = r_gnt;
    w_valid_d = r_valid;
    w_idx_d   = r_idx;
    w_last_d  = r_last;
    if (w_grant_new) begin
      w_gnt_d   = ONE_HOT0 << w_new_idx;
      w_valid_d = 1'b1;
      w_idx_d   = w_new_idx;
      w_last_d  = w_new_idx;
    end else if (w_drop) begin
      w_gnt_d   = '0;
      w_valid_d = 1'b0;
    end
  end

  // State and output registers; pointer resets so requester 0 goes first.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_state   <= StIdle;
      r_gnt     <= '0;
      r_valid   <= 1'b0;
      r_idx     <= '0;
      r_last    <= LAST_RST;
      r_hold    <= '0;
      r_preempt <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_gnt     <= w_gnt_d;
      r_valid   <= w_valid_d;
      r_idx     <= w_idx_d;
      r_last    <= w_last_d;
      r_hold    <= w_hold_d;
      r_preempt <= w_preempt_d;
    end
  end

  assign o_gnt       = r_gnt;
  assign o_gnt_valid = r_valid;
  assign o_gnt_idx   = r_idx;
  assign o_preempt   = r_preempt;

endmodule

// File: tb/tb_rr_arbiter.sv
// Testbench for rr_arbiter: directed vector table, hand-written multi-cycle
// sequences, and randomized traffic checked against a behavioural model.
module tb_rr_arbiter;
  localparam int N  = 4;
  localparam int MH = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req = 4'b0000;
  logic [3:0] gnt;
  logic       gv;
  logic [1:0] gidx;
  logic       pre;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] req;
    logic [3:0] gnt;
    logic       v;
    logic [1:0] idx;
    logic       pre;
  } vec_t;
  vec_t tbl[$];

  // Reference model state: owner (-1 = idle), last winner, tenure length.
  int   m_owner;
  int   m_last;
  int   m_ten;
  int   m_idx;
  logic m_pre;

  rr_arbiter #(.NUM_REQ(N), .MAX_HOLD(MH)) dut (
    .i_clock    (clk),
    .i_reset    (rst_n),
    .i_req      (req),
    .o_gnt      (gnt),
    .o_gnt_valid(gv),
    .o_gnt_idx  (gidx),
    .o_preempt  (pre)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int rr_next(input int base, input logic [3:0] v);
    int j;
    for (int i = 1; i <= N; i++) begin
      j = (base + i) % N;
      if (v[j]) return j;
    end
    return -1;
  endfunction

  function automatic logic [3:0] onehot(input int o);
    logic [3:0] t;
    t = 4'b0001;
    if (o < 0) return 4'b0000;
    return t << o;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_last  = N - 1;
    m_ten   = 0;
    m_idx   = 0;
    m_pre   = 1'b0;
  endtask

  // One clock edge of the arbitration rules, given the sampled request vector.
  task automatic model_step(input logic [3:0] r);
    logic [3:0] oth;
    int nx;
    m_pre = 1'b0;
    if (m_owner < 0) begin
      nx = rr_next(m_last, r);
      if (nx >= 0) begin
        m_owner = nx;
        m_ten   = 1;
      end
    end else begin
      oth = r;
      oth[m_owner] = 1'b0;
      nx = rr_next(m_owner, oth);
      if (!r[m_owner]) begin
        m_owner = nx;
        m_ten   = (nx >= 0) ? 1 : 0;
      end else if (nx < 0) begin
        if (m_ten < MH) m_ten++;
      end else if (MH != 0 && m_ten >= MH) begin
        m_owner = nx;
        m_ten   = 1;
        m_pre   = 1'b1;
      end else begin
        m_ten++;
      end
    end
    if (m_owner >= 0) begin
      m_last = m_owner;
      m_idx  = m_owner;
    end
  endtask

  task automatic check(input string nm, input logic [3:0] eg, input logic ev,
                       input logic [1:0] ei, input logic ep);
    checks++;
    if (gnt !== eg || gv !== ev || gidx !== ei || pre !== ep) begin
      errors++;
      $display("FAIL %s: got gnt=%b valid=%b idx=%0d preempt=%b, want gnt=%b valid=%b idx=%0d preempt=%b",
               nm, gnt, gv, gidx, pre, eg, ev, ei, ep);
    end
    checks++;
    if ($countones(gnt) > 1) begin
      errors++;
      $display("FAIL %s_onehot: got gnt=%b, want at most one bit set", nm, gnt);
    end
  endtask

  task automatic add(input logic [3:0] r, input logic [3:0] g, input logic v,
                     input logic [1:0] i, input logic p);
    vec_t e;
    e.req = r; e.gnt = g; e.v = v; e.idx = i; e.pre = p;
    tbl.push_back(e);
  endtask

  initial begin
    // Directed table: req applied before an edge, outputs expected after it.
    add(4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0);  // idle after reset
    add(4'b0100, 4'b0100, 1'b1, 2'd2, 1'b0);  // single requester, 1-cycle latency
    add(4'b0100, 4'b0100, 1'b1, 2'd2, 1'b0);
    add(4'b0100, 4'b0100, 1'b1, 2'd2, 1'b0);
    add(4'b0000, 4'b0000, 1'b0, 2'd2, 1'b0);  // drop; idx holds last owner
    add(4'b0010, 4'b0010, 1'b1, 2'd1, 1'b0);  // owner 1
    add(4'b0011, 4'b0010, 1'b1, 2'd1, 1'b0);  // contended hold
    add(4'b0001, 4'b0001, 1'b1, 2'd0, 1'b0);  // release handover, no gap
    add(4'b0000, 4'b0000, 1'b0, 2'd0, 1'b0);
    add(4'b0001, 4'b0001, 1'b1, 2'd0, 1'b0);  // owner 0, tenure 1
    for (int i = 0; i < 7; i++) add(4'b1001, 4'b0001, 1'b1, 2'd0, 1'b0);  // tenure 2..8
    add(4'b1000, 4'b1000, 1'b1, 2'd3, 1'b0);  // release at expiry edge: no preempt
    add(4'b0000, 4'b0000, 1'b0, 2'd3, 1'b0);

    // Reset held with all requests high: no grant.
    rst_n = 1'b0;
    req   = 4'b1111;
    repeat (5) begin
      @(posedge clk);
      #1 check("reset_held", 4'b0000, 1'b0, 2'd0, 1'b0);
    end
    @(negedge clk);
    req   = 4'b0000;
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      @(negedge clk);
      req = tbl[i].req;
      @(posedge clk);
      #1 check($sformatf("vec%0d", i), tbl[i].gnt, tbl[i].v, tbl[i].idx, tbl[i].pre);
    end

    // All requesters continuously: MAX_HOLD cycles each in order, preempt per handover.
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      req = 4'b1111;
      @(posedge clk);
      #1 check($sformatf("rr_k%0d", k), onehot((k / MH) % N), 1'b1, 2'((k / MH) % N),
               (k > 0) && (k % MH == 0));
    end

    // Owner 0 releases; requester 1 takes over, then async reset mid-grant.
    @(negedge clk);
    req = 4'b0010;
    @(posedge clk);
    #1 check("release_to_1", 4'b0010, 1'b1, 2'd1, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check("async_reset", 4'b0000, 1'b0, 2'd0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1 check("after_reset_1", 4'b0010, 1'b1, 2'd1, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    req   = 4'b1111;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1 check("prio0_after_reset", 4'b0001, 1'b1, 2'd0, 1'b0);

    // Randomized traffic with sticky request bits against the model.
    @(negedge clk);
    rst_n = 1'b0;
    req   = 4'b0000;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      for (int b = 0; b < N; b++) begin
        if ($urandom_range(0, 7) == 0) req[b] = ~req[b];
      end
      @(posedge clk);
      model_step(req);
      #1 check($sformatf("rand_c%0d", c), onehot(m_owner), m_owner >= 0, 2'(m_idx), m_pre);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
